// File: rtl/bpsk_packet_tx.sv
// Ping-pong packet buffer feeding a framed BPSK triangle-carrier DAC driver.
// Define BPSK_TX_CRC_EN to append a CRC-8 (poly 0x07, init 0x00) after the payload.
module bpsk_packet_tx #(
    parameter int unsigned PACKET_BYTES   = 11,
    parameter int unsigned DATA_WIDTH     = 12,
    parameter int unsigned SYMBOL_CYCLES  = 64,
    parameter int unsigned CARRIER_CYCLES = 16,
    parameter int unsigned PREAMBLE_BITS  = 16,
    parameter logic [7:0]  SYNC_WORD      = 8'hD3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] dac_out,
    output logic                  tx_active,
    output logic                  tx_bit,
    output logic                  frame_done,
    output logic [1:0]            buf_full
);
    localparam int unsigned PAYLOAD_BITS = 8 * PACKET_BYTES;
    localparam int unsigned MAX_BITS = (PAYLOAD_BITS > PREAMBLE_BITS) ? PAYLOAD_BITS
                                                                       : PREAMBLE_BITS;
    localparam int unsigned IDX_W  = $clog2(MAX_BITS);
    localparam int unsigned BYTE_W = (PACKET_BYTES > 1) ? $clog2(PACKET_BYTES) : 1;
    localparam int unsigned CYC_W  = $clog2(SYMBOL_CYCLES);
    localparam int unsigned PH_W   = $clog2(CARRIER_CYCLES);
    localparam logic [DATA_WIDTH:0] STEP =
        (DATA_WIDTH+1)'((2 ** (DATA_WIDTH + 1)) / CARRIER_CYCLES);
    localparam logic [DATA_WIDTH-1:0] MID = {1'b1, {(DATA_WIDTH-1){1'b0}}};

`ifdef BPSK_TX_CRC_EN
    typedef enum logic [2:0] {StIdle, StPreamble, StSync, StPayload, StCrc} state_t;
`else
    typedef enum logic [1:0] {StIdle, StPreamble, StSync, StPayload} state_t;
`endif

    state_t state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CYC_W-1:0]  cyc_q, cyc_d;
    logic              rd_sel_q, rd_sel_d, wr_sel_q, wr_sel_d;
    logic [BYTE_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [1:0]        full_q, full_d;
    logic              tx_bit_q;
    logic [DATA_WIDTH-1:0] dac_q;
`ifdef BPSK_TX_CRC_EN
    logic [7:0] crc_q, crc_d;
`endif

    logic [7:0] mem [2][PACKET_BYTES];

    logic accept, wr_last, bit_end, frame_end, bit_d;
    logic [BYTE_W-1:0]     byte_sel;
    logic [PH_W-1:0]       ph_d;
    logic [DATA_WIDTH:0]   tri_full;
    logic [DATA_WIDTH-1:0] tri_val, sample;

    assign in_ready   = ~rst & ~full_q[wr_sel_q];
    assign accept     = in_valid & in_ready;
    assign wr_last    = (wr_cnt_q == BYTE_W'(PACKET_BYTES - 1));
    assign bit_end    = (cyc_q == CYC_W'(SYMBOL_CYCLES - 1));
    assign dac_out    = dac_q;
    assign tx_active  = (state_q != StIdle);
    assign tx_bit     = tx_bit_q;
    assign frame_done = frame_end;
    assign buf_full   = full_q;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cyc_d     = cyc_q;
        frame_end = 1'b0;
`ifdef BPSK_TX_CRC_EN
        crc_d     = crc_q;
`endif
        if (state_q == StIdle) begin
            if (full_q[rd_sel_q]) begin
                state_d = StPreamble;
                idx_d   = '0;
                cyc_d   = '0;
`ifdef BPSK_TX_CRC_EN
                crc_d   = '0;
`endif
            end
        end else begin
            cyc_d = bit_end ? '0 : cyc_q + 1'b1;
            if (bit_end) begin
                idx_d = idx_q + 1'b1;
                case (state_q)
                    StPreamble: if (idx_q == IDX_W'(PREAMBLE_BITS - 1)) begin
                        state_d = StSync;
                        idx_d   = '0;
                    end
                    StSync: if (idx_q == IDX_W'(7)) begin
                        state_d = StPayload;
                        idx_d   = '0;
                    end
                    StPayload: begin
`ifdef BPSK_TX_CRC_EN
                        // tx_bit_q holds the payload bit that is finishing now
                        crc_d = {crc_q[6:0], 1'b0} ^ ((crc_q[7] ^ tx_bit_q) ? 8'h07 : 8'h00);
                        if (idx_q == IDX_W'(PAYLOAD_BITS - 1)) begin
                            state_d = StCrc;
                            idx_d   = '0;
                        end
`else
                        if (idx_q == IDX_W'(PAYLOAD_BITS - 1)) frame_end = 1'b1;
`endif
                    end
`ifdef BPSK_TX_CRC_EN
                    StCrc: if (idx_q == IDX_W'(7)) frame_end = 1'b1;
`endif
                    default: ;
                endcase
            end
            if (frame_end) begin
                idx_d   = '0;
                state_d = full_q[~rd_sel_q] ? StPreamble : StIdle;
            end
        end

        full_d = full_q;
        if (frame_end) full_d[rd_sel_q] = 1'b0;
        if (accept && wr_last) full_d[wr_sel_q] = 1'b1;
        wr_cnt_d = accept ? (wr_last ? '0 : wr_cnt_q + 1'b1) : wr_cnt_q;
        wr_sel_d = wr_sel_q ^ (accept & wr_last);
        rd_sel_d = rd_sel_q ^ frame_end;
    end

    // DAC and tx_bit are registered from next-state values so they line up with state_q.
    always_comb begin
        byte_sel = BYTE_W'(idx_d >> 3);
        bit_d    = 1'b0;
        case (state_d)
            StPreamble: bit_d = ~idx_d[0];
            StSync:     bit_d = SYNC_WORD[~idx_d[2:0]];
            StPayload:  bit_d = mem[rd_sel_d][byte_sel][~idx_d[2:0]];
`ifdef BPSK_TX_CRC_EN
            StCrc:      bit_d = crc_d[~idx_d[2:0]];
`endif
            default:    bit_d = 1'b0;
        endcase
        ph_d = cyc_d[PH_W-1:0];
        if (!ph_d[PH_W-1]) begin
            tri_full = (DATA_WIDTH+1)'(ph_d) * STEP;
        end else begin
            tri_full = ((DATA_WIDTH+1)'(CARRIER_CYCLES) - (DATA_WIDTH+1)'(ph_d)) * STEP;
        end
        tri_val = tri_full[DATA_WIDTH] ? '1 : tri_full[DATA_WIDTH-1:0];
        sample  = bit_d ? tri_val : ~tri_val;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            cyc_q    <= '0;
            rd_sel_q <= 1'b0;
            wr_sel_q <= 1'b0;
            wr_cnt_q <= '0;
            full_q   <= '0;
            tx_bit_q <= 1'b0;
            dac_q    <= MID;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cyc_q    <= cyc_d;
            rd_sel_q <= rd_sel_d;
            wr_sel_q <= wr_sel_d;
            wr_cnt_q <= wr_cnt_d;
            full_q   <= full_d;
            tx_bit_q <= (state_d == StIdle) ? 1'b0 : bit_d;
            dac_q    <= (state_d == StIdle) ? MID : sample;
        end
    end

`ifdef BPSK_TX_CRC_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) crc_q <= '0;
        else     crc_q <= crc_d;
    end
`endif

    always_ff @(posedge clk) begin
        if (accept) mem[wr_sel_q][wr_cnt_q] <= in_data;
    end

endmodule

// File: tb/tb_bpsk_packet_tx.sv
// Bench for bpsk_packet_tx: frame-level model checked every cycle plus hand-computed points.
module tb_bpsk_packet_tx;
    localparam int PB  = 11;
    localparam int DW  = 12;
    localparam int SC  = 64;
    localparam int CC  = 16;
    localparam int PRE = 16;
`ifdef BPSK_TX_CRC_EN
    localparam int CRCB      = 8;
    localparam int FLEN_HAND = 7680;
`else
    localparam int CRCB      = 0;
    localparam int FLEN_HAND = 7168;
`endif
    localparam int NBITS = PRE + 8 + 8 * PB + CRCB;
    localparam int FLEN  = NBITS * SC;
    localparam int MAXV  = (1 << DW) - 1;
    localparam int MID   = 1 << (DW - 1);
    localparam int STEP  = (1 << (DW + 1)) / CC;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] dac_out;
    logic          tx_active, tx_bit, frame_done;
    logic [1:0]    buf_full;

    int checks = 0;
    int errors = 0;

    bit         m_active = 0;
    int         m_t = 0, m_comp = 0, m_rel = 0, m_fill = 0;
    logic [7:0] m_bytes[$];
    bit         m_bits[NBITS];

    int done_cnt = 0;
    int gap_cnt = 0;
    bit tc_win = 0;

    bpsk_packet_tx #(
        .PACKET_BYTES(PB), .DATA_WIDTH(DW), .SYMBOL_CYCLES(SC),
        .CARRIER_CYCLES(CC), .PREAMBLE_BITS(PRE), .SYNC_WORD(8'hD3)
    ) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .dac_out(dac_out), .tx_active(tx_active), .tx_bit(tx_bit),
        .frame_done(frame_done), .buf_full(buf_full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int tri_at(input int p);
        int v;
        v = (p < CC / 2) ? p * STEP : (CC - p) * STEP;
        return (v > MAXV) ? MAXV : v;
    endfunction

    function automatic int sample_at(input bit b, input int t);
        return b ? tri_at(t % CC) : MAXV - tri_at(t % CC);
    endfunction

    // Build the on-air bit list of the oldest complete packet.
    task automatic start_frame();
        logic [7:0] sync_v, crc, byt;
        int n;
        sync_v = 8'hD3;
        crc = '0;
        n = 0;
        for (int i = 0; i < PRE; i++) begin m_bits[n] = (i % 2 == 0); n++; end
        for (int i = 7; i >= 0; i--) begin m_bits[n] = sync_v[i]; n++; end
        for (int k = 0; k < PB; k++) begin
            byt = m_bytes[k];
            for (int i = 7; i >= 0; i--) begin
                m_bits[n] = byt[i];
                n++;
                crc = {crc[6:0], 1'b0} ^ ((crc[7] ^ byt[i]) ? 8'h07 : 8'h00);
            end
        end
        if (CRCB > 0) for (int i = 7; i >= 0; i--) begin m_bits[n] = crc[i]; n++; end
        m_active = 1;
        m_t = 0;
    endtask

    initial begin : model
        bit acc, exp_ready;
        int occ, exp_full, exp_bit, exp_dac;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_active = 0; m_t = 0; m_comp = 0; m_rel = 0; m_fill = 0;
                m_bytes.delete();
                chk("reset_dac", dac_out, MID);
                chk("reset_tx_active", tx_active, 0);
                chk("reset_tx_bit", tx_bit, 0);
                chk("reset_frame_done", frame_done, 0);
                chk("reset_buf_full", buf_full, 0);
                chk("reset_in_ready", in_ready, 0);
            end else begin
                occ = m_comp - m_rel;
                exp_ready = (occ < 2);
                exp_full = 0;
                for (int n = m_rel; n < m_comp; n++) exp_full |= (1 << (n % 2));
                if (m_active) begin
                    exp_bit = m_bits[m_t / SC];
                    exp_dac = sample_at(m_bits[m_t / SC], m_t);
                end else begin
                    exp_bit = 0;
                    exp_dac = MID;
                end
                chk("dac_out", dac_out, exp_dac);
                chk("tx_active", tx_active, m_active);
                chk("tx_bit", tx_bit, exp_bit);
                chk("frame_done", frame_done, (m_active && m_t == FLEN - 1));
                chk("buf_full", buf_full, exp_full);
                chk("in_ready", in_ready, exp_ready);

                acc = in_valid && exp_ready;
                if (m_active) begin
                    if (m_t == FLEN - 1) begin
                        m_rel++;
                        for (int i = 0; i < PB; i++) void'(m_bytes.pop_front());
                        if (m_comp - m_rel >= 1) start_frame();
                        else m_active = 0;
                    end else begin
                        m_t++;
                    end
                end else if (occ >= 1) begin
                    start_frame();
                end
                if (acc) begin
                    m_bytes.push_back(in_data);
                    m_fill++;
                    if (m_fill == PB) begin m_comp++; m_fill = 0; end
                end
            end
        end
    end

    always @(posedge clk) begin
        if (!rst && frame_done) done_cnt <= done_cnt + 1;
        if (tc_win && !tx_active) gap_cnt <= gap_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        bit got;
        int k;
        in_valid = 1'b1;
        in_data  = b;
        got = 0;
        k = 0;
        while (!got && k < 20000) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            #1;
            k++;
        end
        in_valid = 1'b0;
        if (!got) chk("send_timeout", 0, 1);
    endtask

    task automatic wait_rise();
        int k;
        k = 0;
        while (!tx_active && k < 20000) begin tick(); k++; end
        chk("rise_timeout", tx_active, 1);
    endtask

    initial begin : watchdog
        #1500000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [7:0] sync_got;
        int done_t, base, g0, k;
        repeat (3) tick();
        rst = 1'b0;

        // Single frame of 0xA5 bytes.
        for (int i = 0; i < PB; i++) send(8'hA5);
        chk("idle_after_fill", tx_active, 0);
        chk("full_after_fill", buf_full, 1);
        tick();
        chk("active_rise", tx_active, 1);
        done_t = -1;
        sync_got = '0;
        for (int t = 0; t <= FLEN; t++) begin
            if (t > 0) tick();
            if (t == 0) chk("first_sample", dac_out, 0);
            if (t == 4) chk("p4_sample", dac_out, 2048);
            if (t == 8) chk("p8_sample", dac_out, 4095);
            if (t == SC) chk("bit0_p0_sample", dac_out, 4095);
            if (t > 0 && t % SC == 0 && t <= (PRE + 8) * SC)
                chk("boundary_p0", (dac_out == 0 || dac_out == 4095), 1);
            if (t >= PRE * SC && t < (PRE + 8) * SC && t % SC == SC / 2)
                sync_got = {sync_got[6:0], tx_bit};
            if (frame_done && done_t < 0) done_t = t;
        end
        chk("sync_word", sync_got, 8'hD3);
        chk("frame_len", done_t + 1, FLEN_HAND);
        chk("fall_after_frame", tx_active, 0);

        // Reset in the middle of the payload, then a clean frame.
        for (int i = 0; i < PB; i++) send(8'(i * 7 + 3));
        wait_rise();
        repeat (3000) tick();
        rst = 1'b1;
        #1;
        chk("midframe_rst_dac", dac_out, 2048);
        chk("midframe_rst_active", tx_active, 0);
        chk("midframe_rst_buf", buf_full, 0);
        tick();
        tick();
        rst = 1'b0;
        base = done_cnt;
        for (int i = 0; i < PB; i++) send(8'(8'hC0 + i));
        wait_rise();
        chk("post_rst_first_sample", dac_out, 0);
        k = 0;
        while (done_cnt == base && k < 10000) begin tick(); k++; end
        chk("post_rst_frames", done_cnt - base, 1);

        // Three packets back to back from a fresh reset.
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        base = done_cnt;
        g0 = 0;
        for (int i = 0; i < 3 * PB; i++) begin
            send(8'(8'h40 + i));
            if (i == PB - 1) chk("c_full_01", buf_full, 1);
            if (i == PB) begin
                chk("c_active", tx_active, 1);
                tc_win = 1;
                g0 = gap_cnt;
            end
            if (i == 2 * PB - 1) begin
                chk("c_full_11", buf_full, 3);
                chk("c_ready_low", in_ready, 0);
            end
            if (i == 2 * PB) begin
                chk("c_active_swap", tx_active, 1);
                chk("c_full_10", buf_full, 2);
            end
        end
        k = 0;
        while (done_cnt - base < 3 && k < 25000) begin tick(); k++; end
        tc_win = 0;
        chk("c_frames", done_cnt - base, 3);
        chk("c_no_gap", gap_cnt - g0, 0);
        chk("c_idle_end", tx_active, 0);

        repeat (4) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bpsk_packet_tx.md
Name: bpsk_packet_tx

Overview:
- Parametrised successor to the single-packet BPSK transmit chain.
- Accepts bytes over a valid/ready stream into a two-deep packet ping-pong buffer, so the next packet fills while the current one transmits.
- Frames each packet as preamble, sync word, payload and optional CRC, then drives a BPSK-modulated triangle carrier straight to the parallel DAC pins.
- Sits between the UART byte reader and the DAC pin assignments, replacing the buffer / sorter / serialiser / modulator chain.

Parameters:
- PACKET_BYTES, 11: payload bytes per frame (≥1).
- DATA_WIDTH, 12: DAC sample width.
- SYMBOL_CYCLES, 64: clk cycles per bit; must be an integer multiple of CARRIER_CYCLES.
- CARRIER_CYCLES, 16: clk cycles per carrier period; power of two, ≥4.
- PREAMBLE_BITS, 16: length of the alternating preamble.
- SYNC_WORD, 8'hD3: sync byte, sent MSB first.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  8  payload byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  byte accepted on a clk edge when in_valid && in_ready.
- dac_out  out  DATA_WIDTH  registered DAC sample.
- tx_active  out  1  high while a frame is on air.
- tx_bit  out  1  bit currently being modulated (0 when idle).
- frame_done  out  1  one-cycle pulse on the final cycle of a frame.
- buf_full  out  2  per-buffer full flags (debug / LEDs).

Behaviour:
- Reset (async, rst=1):
  - Both buffers emptied; wr_sel=0, rd_sel=0; FSM=IDLE.
  - dac_out = 2^(DATA_WIDTH-1) (2048 at default); tx_active=0, tx_bit=0, frame_done=0, buf_full=0.
  - in_ready=0 while rst is high, 1 after release.
  - Reset mid-frame aborts immediately; the partial packet is discarded.
- Input side:
  - in_ready = !full[wr_sel] (combinational).
  - Accepted bytes are written at index wr_cnt, which then increments.
  - On accepting byte PACKET_BYTES-1: full[wr_sel] sets, wr_cnt clears, wr_sel toggles.
  - If the new wr_sel buffer is still full, in_ready drops until it is released.
  - Unaccepted in_valid is held by the source; no loss.
- FSM states IDLE, PREAMBLE, SYNC, PAYLOAD, CRC (CRC only with the feature enabled). Each bit lasts exactly SYMBOL_CYCLES clk.
  - IDLE → PREAMBLE when full[rd_sel]=1. tx_active rises on the clk edge after the edge that set full; dac_out carries the first preamble sample in that same cycle.
  - PREAMBLE: PREAMBLE_BITS bits, alternating, starting with 1.
  - SYNC: 8 bits of SYNC_WORD, MSB first.
  - PAYLOAD: bytes 0..PACKET_BYTES-1 in arrival order, each MSB first.
  - After the last bit (PAYLOAD, or CRC if enabled):
    - frame_done pulses on that bit's final cycle.
    - full[rd_sel] clears at the following edge and rd_sel toggles.
    - If the other buffer is already full, the FSM goes directly to PREAMBLE with tx_active held high (no idle gap); otherwise it goes to IDLE.
  - The simultaneous release and accept of the final byte into the freed buffer is legal: the release takes effect first and in_ready sees the new state next cycle.
- Carrier:
  - Phase counter p (0..CARRIER_CYCLES-1) resets to 0 at every frame start and is free-running within the frame.
  - step = 2^(DATA_WIDTH+1)/CARRIER_CYCLES.
  - tri = p·step for p < CARRIER_CYCLES/2, else (CARRIER_CYCLES-p)·step; saturate to 2^DATA_WIDTH-1.
  - Bit 1: dac_out = tri. Bit 0: dac_out = (2^DATA_WIDTH-1) - tri.
  - Idle: dac_out = midscale.
  - Symbol boundaries fall on p=0, so every phase flip is carrier-aligned.
- Frame length: (PREAMBLE_BITS + 8 + 8·PACKET_BYTES)·SYMBOL_CYCLES. At defaults this is 112 bits = 7168 cycles.

Optional Feature:
- Macro: BPSK_TX_CRC_EN.
- Defined:
  - A CRC-8 is computed over the payload as it is transmitted: poly 0x07, init 0x00, no reflection, no final XOR.
  - It is sent as 8 additional bits, MSB first, in state CRC.
  - Frame length grows by 8·SYMBOL_CYCLES.
- Undefined: the CRC state and logic are absent; the frame ends after the payload.

Test Plan:
- Reset during PAYLOAD at cycle 3000 → dac_out=2048, tx_active=0, buf_full=2'b00 in the same cycle as rst rises; the next 11 bytes give a clean new frame.
- Write 11 bytes 8'hA5 back-to-back → tx_active rises the cycle after the 11th accept; first sample 0 (p=0, bit 1); sample at p=4 is 2048, at p=8 is 4095; frame_done exactly 7168 cycles after tx_active rose.
- Sync check → bits 17-24 decode to 11010011; each preamble/sync bit boundary sits at p=0; a bit-0 symbol at p=0 outputs 4095.
- Write 33 bytes continuously → in_ready drops after byte 22 and rises on release of buffer 0; three frames run with tx_active never falling between them; buf_full sequence 01, 11, 10/11, …
- Hold in_valid=1 with in_ready=0 for 500 cycles → no byte lost or duplicated; payload order preserved across the buffer swap.
- With BPSK_TX_CRC_EN and PACKET_BYTES=9, payload "123456789" (0x31..0x39) → the CRC bits decode to 0xF4; frame length (16+8+72+8)·64 = 6656 cycles.
